// File: rtl/uart_alu_cmd_if_pkg.sv
// Shared definitions for the UART <-> ALU command engine and the ALU block:
// command FSM state encodings, default widths and a small state helper.
package uart_alu_cmd_if_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int OPCODE_W_DEF    = 6;
    localparam int TIMEOUT_CYC_DEF = 50000;

    typedef logic [2:0] state_t;

    localparam logic [2:0] GET_A   = 3'd0;
    localparam logic [2:0] GET_B   = 3'd1;
    localparam logic [2:0] GET_OP  = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] SEND    = 3'd4;
    localparam logic [2:0] WAIT_TX = 3'd5;

    // States in which an incoming byte has nowhere to go and is thrown away.
    function automatic logic drops_byte(input state_t s);
        return (s == EXEC) || (s == SEND) || (s == WAIT_TX);
    endfunction

endpackage

// File: rtl/uart_alu_cmd_if_if.sv
// Bundle of the UART byte handshake and ALU command/result signals.
// The master modport is the command engine; the slave modport is the
// surrounding UART/ALU logic (or a testbench standing in for it).
interface uart_alu_cmd_if_if
    import uart_alu_cmd_if_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int OPCODE_W = OPCODE_W_DEF
) ();

    logic [DATA_W-1:0]   i_rx_data;
    logic                i_rx_ready;
    logic                i_tx_done;
    logic [DATA_W-1:0]   i_alu_result;
    logic [DATA_W-1:0]   o_tx_data;
    logic                o_tx_start;
    logic [DATA_W-1:0]   o_op_a;
    logic [DATA_W-1:0]   o_op_b;
    logic [OPCODE_W-1:0] o_opcode;
    logic                o_exec;
    logic                o_busy;
    logic                o_overrun;

    modport master (
        input  i_rx_data, i_rx_ready, i_tx_done, i_alu_result,
        output o_tx_data, o_tx_start, o_op_a, o_op_b, o_opcode,
               o_exec, o_busy, o_overrun
    );

    modport slave (
        output i_rx_data, i_rx_ready, i_tx_done, i_alu_result,
        input  o_tx_data, o_tx_start, o_op_a, o_op_b, o_opcode,
               o_exec, o_busy, o_overrun
    );

endinterface

// File: rtl/uart_alu_cmd_if_edge_det.sv
// uart_edge_det: turns a level flag into a registered one-cycle pulse on
// each rising edge. A level held high yields exactly one pulse.
module uart_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_q;

    // Remember last level and emit a pulse when it goes from 0 to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_q <= level;
            pulse   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/uart_alu_cmd_if.sv
// uart_alu_cmd_if: collects three UART bytes (A, B, OPCODE) into an ALU
// command, pulses exec, captures the ALU result and sends it back through
// the UART transmitter, waiting for its done flag before the next command.
// Optional feature macro CMD_TIMEOUT_EN: abandons a partial command when
// no byte arrives for TIMEOUT_CYC cycles while in GET_B/GET_OP.
module uart_alu_cmd_if
    import uart_alu_cmd_if_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
`ifdef CMD_TIMEOUT_EN
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
`endif
    parameter int OPCODE_W    = OPCODE_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    uart_alu_cmd_if_if.master  bus
);

    state_t              state;
    logic                rx_evt;
    logic                tx_evt;
    logic                give_up;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [OPCODE_W-1:0] opcode;
    logic [DATA_W-1:0]   tx_data;

    uart_edge_det u_rx_edge (
        .clk   (i_clk),
        .rst   (i_rst),
        .level (bus.i_rx_ready),
        .pulse (rx_evt)
    );

    uart_edge_det u_tx_edge (
        .clk   (i_clk),
        .rst   (i_rst),
        .level (bus.i_tx_done),
        .pulse (tx_evt)
    );

`ifdef CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] idle_cnt;
    logic             waiting_byte;

    assign waiting_byte = (state == GET_B) || (state == GET_OP);
    assign give_up      = waiting_byte && (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Count idle cycles between command bytes; any byte or state change restarts it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idle_cnt <= '0;
        end else if (waiting_byte && !rx_evt && !give_up) begin
            idle_cnt <= idle_cnt + 1'b1;
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    assign give_up = 1'b0;
`endif

    // Command sequencer: byte collection, execute, result send, wait for done.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= GET_A;
            op_a    <= '0;
            op_b    <= '0;
            opcode  <= '0;
            tx_data <= '0;
        end else begin
            case (state)
                GET_A: begin
                    if (rx_evt) begin
                        op_a  <= bus.i_rx_data;
                        state <= GET_B;
                    end
                end
                GET_B: begin
                    if (rx_evt) begin
                        op_b  <= bus.i_rx_data;
                        state <= GET_OP;
                    end else if (give_up) begin
                        state <= GET_A;
                    end
                end
                GET_OP: begin
                    if (rx_evt) begin
                        opcode <= bus.i_rx_data[OPCODE_W-1:0];
                        state  <= EXEC;
                    end else if (give_up) begin
                        state <= GET_A;
                    end
                end
                EXEC: begin
                    tx_data <= bus.i_alu_result;
                    state   <= SEND;
                end
                SEND: begin
                    state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_evt) begin
                        state <= GET_A;
                    end
                end
                default: begin
                    state <= GET_A;
                end
            endcase
        end
    end

    assign bus.o_op_a      = op_a;
    assign bus.o_op_b      = op_b;
    assign bus.o_opcode    = opcode;
    assign bus.o_tx_data   = tx_data;
    assign bus.o_exec      = (state == EXEC);
    assign bus.o_tx_start  = (state == SEND);
    assign bus.o_busy      = (state != GET_A);
    assign bus.o_overrun   = rx_evt && drops_byte(state);

endmodule

// File: tb/tb_uart_alu_cmd_if.sv
// Testbench for uart_alu_cmd_if. Commands are pushed to a scoreboard as they
// are driven; each o_tx_start pops one entry and checks the captured command
// and the transmitted result. ALU is stubbed as A+B.
// Build with CMD_TIMEOUT_EN defined to also exercise the inter-byte timeout.
module tb_uart_alu_cmd_if;
    import uart_alu_cmd_if_pkg::*;

    localparam int DW = 8;
    localparam int OW = 6;
`ifdef CMD_TIMEOUT_EN
    localparam int TO       = 16;
    localparam int HOLD_CYC = 8;
`else
    localparam int HOLD_CYC = 20;
`endif

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [OW-1:0] op;
        logic [DW-1:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    int   checks = 0;
    int   errors = 0;
    int   exec_cnt = 0;
    int   start_cnt = 0;
    int   overrun_cnt = 0;
    int   pushed = 0;
    logic exec_prev = 1'b0;
    exp_t sb_q[$];

    uart_alu_cmd_if_if #(.DATA_W(DW), .OPCODE_W(OW)) bus ();

    assign bus.i_alu_result = bus.o_op_a + bus.o_op_b;

    uart_alu_cmd_if #(
        .DATA_W      (DW),
`ifdef CMD_TIMEOUT_EN
        .TIMEOUT_CYC (TO),
`endif
        .OPCODE_W    (OW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: pulse counters and scoreboard comparison on each tx start.
    always @(negedge clk) begin
        if (bus.o_exec) exec_cnt++;
        if (bus.o_overrun) overrun_cnt++;
        if (bus.o_tx_start) begin
            exp_t e;
            start_cnt++;
            checkOutput("start_after_exec", exec_prev, 1);
            checkOutput("sb_nonempty", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("sb_op_a", bus.o_op_a, e.a);
                checkOutput("sb_op_b", bus.o_op_b, e.b);
                checkOutput("sb_opcode", bus.o_opcode, e.op);
                checkOutput("sb_tx_data", bus.o_tx_data, e.res);
            end
        end
        exec_prev = bus.o_exec;
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, bus.o_busy, 0);
        checkOutput({tag, "_exec"}, bus.o_exec, 0);
        checkOutput({tag, "_tx_start"}, bus.o_tx_start, 0);
        checkOutput({tag, "_overrun"}, bus.o_overrun, 0);
        checkOutput({tag, "_op_a"}, bus.o_op_a, 0);
        checkOutput({tag, "_op_b"}, bus.o_op_b, 0);
        checkOutput({tag, "_opcode"}, bus.o_opcode, 0);
        checkOutput({tag, "_tx_data"}, bus.o_tx_data, 0);
    endtask

    task automatic applyStimulus(input logic [DW-1:0] b);
        @(negedge clk);
        bus.i_rx_data  = b;
        bus.i_rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.i_rx_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pushCmd(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] op);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.op  = op[OW-1:0];
        e.res = a + b;
        sb_q.push_back(e);
        pushed++;
    endtask

    // Third byte: exec two cycles after the rise, tx start one cycle later.
    task automatic finishCmd(input logic [DW-1:0] b);
        @(negedge clk);
        bus.i_rx_data  = b;
        bus.i_rx_ready = 1'b1;
        @(negedge clk);
        checkOutput("exec_early", bus.o_exec, 0);
        @(negedge clk);
        checkOutput("exec_latency", bus.o_exec, 1);
        checkOutput("start_early", bus.o_tx_start, 0);
        @(negedge clk);
        checkOutput("tx_start_follow", bus.o_tx_start, 1);
        checkOutput("exec_single", bus.o_exec, 0);
        bus.i_rx_ready = 1'b0;
        @(negedge clk);
        checkOutput("start_single", bus.o_tx_start, 0);
        checkOutput("busy_wait_tx", bus.o_busy, 1);
    endtask

    task automatic sendCmd(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] op);
        pushCmd(a, b, op);
        applyStimulus(a);
        applyStimulus(b);
        finishCmd(op);
    endtask

    task automatic completeTx();
        int n;
        n = 0;
        @(negedge clk);
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        while (bus.o_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy_release", bus.o_busy, 0);
        bus.i_tx_done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int e0;
        int o0;
        int s0;

        rst            = 1'b1;
        bus.i_rx_data  = '0;
        bus.i_rx_ready = 1'b0;
        bus.i_tx_done  = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic command 05 03 20");
        e0 = exec_cnt;
        sendCmd(8'h05, 8'h03, 8'h20);
        checkOutput("cmd1_op_a", bus.o_op_a, 8'h05);
        checkOutput("cmd1_op_b", bus.o_op_b, 8'h03);
        checkOutput("cmd1_opcode", bus.o_opcode, 6'h20);
        checkOutput("cmd1_tx_data", bus.o_tx_data, 8'h08);

        $display("[TB] byte during WAIT_TX");
        o0 = overrun_cnt;
        s0 = start_cnt;
        applyStimulus(8'hAA);
        checkOutput("overrun_pulse", overrun_cnt - o0, 1);
        checkOutput("overrun_op_a_kept", bus.o_op_a, 8'h05);
        checkOutput("overrun_no_start", start_cnt - s0, 0);
        checkOutput("overrun_still_busy", bus.o_busy, 1);
        completeTx();
        checkOutput("cmd1_exec_once", exec_cnt - e0, 1);
        checkOutput("cmd1_operand_hold", bus.o_op_a, 8'h05);

        $display("[TB] rx and tx events in the same WAIT_TX cycle");
        sendCmd(8'h10, 8'h20, 8'h01);
        o0 = overrun_cnt;
        @(negedge clk);
        bus.i_rx_data  = 8'h55;
        bus.i_rx_ready = 1'b1;
        bus.i_tx_done  = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("tie_tx_wins", bus.o_busy, 0);
        repeat (2) @(negedge clk);
        bus.i_rx_ready = 1'b0;
        bus.i_tx_done  = 1'b0;
        @(negedge clk);
        checkOutput("tie_overrun", overrun_cnt - o0, 1);
        checkOutput("tie_op_a_kept", bus.o_op_a, 8'h10);
        checkOutput("tie_idle", bus.o_busy, 0);

        $display("[TB] rx_ready held high");
        pushCmd(8'h77, 8'h10, 8'hC5);
        @(negedge clk);
        bus.i_rx_data  = 8'h77;
        bus.i_rx_ready = 1'b1;
        repeat (HOLD_CYC) @(negedge clk);
        bus.i_rx_ready = 1'b0;
        @(negedge clk);
        checkOutput("hold_op_a", bus.o_op_a, 8'h77);
        checkOutput("hold_op_b_kept", bus.o_op_b, 8'h20);
        checkOutput("hold_busy", bus.o_busy, 1);
        applyStimulus(8'h10);
        checkOutput("hold_op_b", bus.o_op_b, 8'h10);
        finishCmd(8'hC5);
        completeTx();
        checkOutput("opcode_trunc", bus.o_opcode, 6'h05);

        $display("[TB] tx_done in GET_B");
        applyStimulus(8'h22);
        s0 = start_cnt;
        @(negedge clk);
        bus.i_tx_done = 1'b1;
        repeat (2) @(negedge clk);
        bus.i_tx_done = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("txdone_ignored_busy", bus.o_busy, 1);
        checkOutput("txdone_no_start", start_cnt - s0, 0);
        checkOutput("txdone_op_b_kept", bus.o_op_b, 8'h10);
        pushCmd(8'h22, 8'h33, 8'h07);
        applyStimulus(8'h33);
        finishCmd(8'h07);
        completeTx();

        $display("[TB] reset during WAIT_TX");
        sendCmd(8'h40, 8'h02, 8'h3F);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkAllZero("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sendCmd(8'h09, 8'h0A, 8'h11);
        completeTx();
        checkOutput("post_reset_op_a", bus.o_op_a, 8'h09);
        checkOutput("post_reset_tx_data", bus.o_tx_data, 8'h13);

`ifdef CMD_TIMEOUT_EN
        $display("[TB] inter-byte timeout");
        e0 = exec_cnt;
        applyStimulus(8'h11);
        checkOutput("timeout_waiting", bus.o_busy, 1);
        repeat (20) @(negedge clk);
        checkOutput("timeout_back_idle", bus.o_busy, 0);
        checkOutput("timeout_no_exec", exec_cnt - e0, 0);
        sendCmd(8'h01, 8'h02, 8'h03);
        completeTx();
        checkOutput("timeout_next_cmd", bus.o_tx_data, 8'h03);
`endif

        repeat (3) @(negedge clk);
        checkOutput("sb_drained", sb_q.size(), 0);
        checkOutput("start_total", start_cnt, pushed);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
